// File: rtl/data_sync_tx_ctrl_if.sv
// Requester handshakes and synchronizer-facing bus of data_sync_tx_ctrl.
// slave = sequencer side, master = requesters / destination side.
interface data_sync_tx_ctrl_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 req_a;
  logic [BUS_WIDTH-1:0] data_a;
  logic                 gnt_a;
  logic                 req_b;
  logic [BUS_WIDTH-1:0] data_b;
  logic                 gnt_b;
  logic                 bus_enable;
  logic [BUS_WIDTH-1:0] UNSYNC_bus;
  logic                 busy;
  logic                 done;

  modport slave (
    input  req_a,
    input  data_a,
    output gnt_a,
    input  req_b,
    input  data_b,
    output gnt_b,
    output bus_enable,
    output UNSYNC_bus,
    output busy,
    output done
  );

  modport master (
    output req_a,
    output data_a,
    input  gnt_a,
    output req_b,
    output data_b,
    input  gnt_b,
    input  bus_enable,
    input  UNSYNC_bus,
    input  busy,
    input  done
  );
endinterface

// File: rtl/data_sync_tx_ctrl.sv
// Two-requester sequencer feeding one bus synchronizer channel.
// Define DSYNC_TX_RR_EN for round-robin; default is fixed priority A>B.
module data_sync_tx_ctrl #(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 6,
  parameter int GAP_CYCLES  = 6
) (
  input logic              CLK,
  input logic              RST_n,
  data_sync_tx_ctrl_if.slave bus
);

  localparam int MAX_CYC =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [BUS_WIDTH-1:0] word_q;
  logic [BUS_WIDTH-1:0] word_d;
  logic                 gnt_a_q;
  logic                 gnt_a_d;
  logic                 gnt_b_q;
  logic                 gnt_b_d;
  logic                 en_q;
  logic                 en_d;
  logic                 busy_q;
  logic                 busy_d;
  logic                 done_q;
  logic                 done_d;
  logic                 pick_a;
  logic                 pick_b;

`ifdef DSYNC_TX_RR_EN
  // last_b_q set means B was granted most recently, so A wins a tie
  logic last_b_q;

  always_comb begin
    pick_a = bus.req_a & (~bus.req_b | last_b_q);
    pick_b = bus.req_b & ~pick_a;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      last_b_q <= 1'b1;
    end else if (gnt_a_d) begin
      last_b_q <= 1'b0;
    end else if (gnt_b_d) begin
      last_b_q <= 1'b1;
    end
  end
`else
  always_comb begin
    pick_a = bus.req_a;
    pick_b = bus.req_b & ~bus.req_a;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_a: begin
            word_d  = bus.data_a;
            gnt_a_d = 1'b1;
            state_d = SETUP;
          end
          pick_b: begin
            word_d  = bus.data_b;
            gnt_b_d = 1'b1;
            state_d = SETUP;
          end
          default: ;
        endcase
      end
      SETUP: begin
        state_d = HIGH;
        cnt_d   = HOLD_LD;
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    en_d   = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt_a      = gnt_a_q;
  assign bus.gnt_b      = gnt_b_q;
  assign bus.bus_enable = en_q;
  assign bus.UNSYNC_bus = word_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_data_sync_tx_ctrl.sv
// Directed bench for data_sync_tx_ctrl with a 4-stage destination
// synchronizer model on the same clock.
module tb_data_sync_tx_ctrl;

`ifdef DSYNC_TX_RR_EN
  localparam bit RR = 1'b1;
  localparam logic [3:0] SEQ_A = 4'b0101;
`else
  localparam bit RR = 1'b0;
  localparam logic [3:0] SEQ_A = 4'b0111;
`endif

  logic CLK;
  logic RST_n;
  int   checks;
  int   errors;
  int   ndone;
  int   ngnt_b;
  int   sync_cnt;
  int   gb_snap;
  logic [3:0] ss;
  logic       sd;
  logic [7:0] sync_word;
  logic [7:0] exp_w;

  data_sync_tx_ctrl_if #(.BUS_WIDTH(8)) bus_if ();

  data_sync_tx_ctrl #(
    .BUS_WIDTH  (8),
    .HOLD_CYCLES(6),
    .GAP_CYCLES (6)
  ) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    ndone  = 0;
    ngnt_b = 0;
  end

  always @(negedge CLK) begin
    if (bus_if.done === 1'b1) ndone++;
    if (bus_if.gnt_b === 1'b1) ngnt_b++;
  end

  // destination side: 4 flops, rising-edge detect, capture
  initial begin
    sync_cnt  = 0;
    sync_word = '0;
  end

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ss <= '0;
      sd <= 1'b0;
    end else begin
      ss <= {ss[2:0], bus_if.bus_enable};
      sd <= ss[3];
      if (ss[3] && !sd) begin
        sync_word <= bus_if.UNSYNC_bus;
        sync_cnt  <= sync_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST_n = 1'b0;
    bus_if.req_a  = 1'b0;
    bus_if.req_b  = 1'b0;
    bus_if.data_a = '0;
    bus_if.data_b = '0;
    #12;
    chk("rst_en", 32'(bus_if.bus_enable), 0);
    chk("rst_bus", 32'(bus_if.UNSYNC_bus), 0);
    chk("rst_gnt", {bus_if.gnt_a, bus_if.gnt_b}, 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_done", 32'(bus_if.done), 0);

    // single A transfer
    @(negedge CLK);
    RST_n = 1'b1;
    bus_if.req_a  = 1'b1;
    bus_if.data_a = 8'hF2;
    step(1);
    chk("t1_gnt", {bus_if.gnt_a, bus_if.gnt_b}, 2'b10);
    chk("t1_bus", 32'(bus_if.UNSYNC_bus), 32'hF2);
    chk("t1_busy", 32'(bus_if.busy), 1);
    chk("t1_setup_en", 32'(bus_if.bus_enable), 0);
    bus_if.req_a = 1'b0;
    step(1);
    chk("t1_gnt_off", 32'(bus_if.gnt_a), 0);
    chk("t1_en_rise", 32'(bus_if.bus_enable), 1);
    step(5);
    chk("t1_en_last", 32'(bus_if.bus_enable), 1);
    step(1);
    chk("t1_en_fall", 32'(bus_if.bus_enable), 0);
    chk("t1_busy_low", 32'(bus_if.busy), 1);
    step(5);
    chk("t1_no_early_done", 32'(bus_if.done), 0);
    step(1);
    chk("t1_done", 32'(bus_if.done), 1);
    chk("t1_busy_end", 32'(bus_if.busy), 0);
    chk("t1_bus_hold", 32'(bus_if.UNSYNC_bus), 32'hF2);
    chk("t1_sync_cnt", sync_cnt, 1);
    chk("t1_sync_word", 32'(sync_word), 32'hF2);
    step(1);
    chk("t1_done_pulse", 32'(bus_if.done), 0);

    // both requesting
    RST_n = 1'b0;
    #4;
    @(negedge CLK);
    RST_n = 1'b1;
    bus_if.req_a  = 1'b1;
    bus_if.data_a = 8'hAA;
    bus_if.req_b  = 1'b1;
    bus_if.data_b = 8'hBB;
    for (int i = 0; i < 4; i++) begin
      step(1);
      exp_w = SEQ_A[i] ? 8'hAA : 8'hBB;
      chk($sformatf("t2_gnt%0d", i), {bus_if.gnt_a, bus_if.gnt_b},
          SEQ_A[i] ? 2'b10 : 2'b01);
      chk($sformatf("t2_bus%0d", i), 32'(bus_if.UNSYNC_bus), 32'(exp_w));
      if (i == 2 && !RR) bus_if.req_a = 1'b0;
      if (i == 3) begin
        bus_if.req_a = 1'b0;
        bus_if.req_b = 1'b0;
      end
      step(1);
      chk($sformatf("t2_gnt1cy%0d", i), {bus_if.gnt_a, bus_if.gnt_b}, 0);
      step(12);
      chk($sformatf("t2_done%0d", i), 32'(bus_if.done), 1);
      chk($sformatf("t2_sync_cnt%0d", i), sync_cnt, 2 + i);
      chk($sformatf("t2_sync_word%0d", i), 32'(sync_word), 32'(exp_w));
    end

    // B pulse during HIGH is ignored
    gb_snap = ngnt_b;
    bus_if.req_a  = 1'b1;
    bus_if.data_a = 8'h11;
    step(1);
    chk("t3_gnt", {bus_if.gnt_a, bus_if.gnt_b}, 2'b10);
    bus_if.req_a = 1'b0;
    step(2);
    bus_if.req_b  = 1'b1;
    bus_if.data_b = 8'h22;
    step(2);
    bus_if.req_b = 1'b0;
    step(9);
    chk("t3_done", 32'(bus_if.done), 1);
    step(14);
    chk("t3_no_gnt_b", ngnt_b, gb_snap);
    chk("t3_idle", 32'(bus_if.busy), 0);
    chk("t3_bus", 32'(bus_if.UNSYNC_bus), 32'h11);
    chk("t3_sync_cnt", sync_cnt, 6);

    // reset mid-HIGH
    bus_if.req_a  = 1'b1;
    bus_if.data_a = 8'h5A;
    step(1);
    chk("t4_gnt", 32'(bus_if.gnt_a), 1);
    bus_if.req_a = 1'b0;
    step(3);
    chk("t4_high", 32'(bus_if.bus_enable), 1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("t4_rst_en", 32'(bus_if.bus_enable), 0);
    chk("t4_rst_busy", 32'(bus_if.busy), 0);
    chk("t4_rst_bus", 32'(bus_if.UNSYNC_bus), 0);
    chk("t4_rst_done", 32'(bus_if.done), 0);
    #2;
    RST_n = 1'b1;
    bus_if.req_b  = 1'b1;
    bus_if.data_b = 8'hCC;
    step(1);
    chk("t4_gnt_b", {bus_if.gnt_a, bus_if.gnt_b}, 2'b01);
    chk("t4_bus_cc", 32'(bus_if.UNSYNC_bus), 32'hCC);
    bus_if.req_b = 1'b0;
    step(13);
    chk("t4_done", 32'(bus_if.done), 1);
    chk("t4_sync_word", 32'(sync_word), 32'hCC);
    step(2);
    chk("total_done", ndone, 7);
    chk("total_sync", sync_cnt, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sync_tx_ctrl.md
# data_sync_tx_ctrl

Source-domain sequencer that shares one multi-flop bus synchronizer channel between two requesters. It arbitrates requests and registers the winning word onto the unsynchronized bus. It then drives the bus enable with a set-up / high / low sequence long enough for the destination synchronizer to detect a rising edge and capture the data. It sits in the transmitting clock domain, directly in front of the destination-side data synchronizer.

## Interface
- BUS_WIDTH, 8, width of data words and UNSYNC_bus
- HOLD_CYCLES, 6, CLK cycles bus_enable stays high per transfer (≥1; set ≥ destination sync stages + 2 destination cycles, scaled by clock ratio)
- GAP_CYCLES, 6, CLK cycles bus_enable stays low after each high phase (≥1)
- CLK  in  1  source-domain clock
- RST_n  in  1  asynchronous, active-low reset
- req_a  in  1  requester A level request; data_a valid while high
- data_a  in  BUS_WIDTH  requester A word
- gnt_a  out  1  one-cycle pulse: A's word accepted
- req_b  in  1  requester B level request
- data_b  in  BUS_WIDTH  requester B word
- gnt_b  out  1  one-cycle pulse: B's word accepted
- bus_enable  out  1  enable level to destination synchronizer
- UNSYNC_bus  out  BUS_WIDTH  registered data to destination synchronizer
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at end of each transfer's low gap

## Operation
- All outputs registered. Reset values: bus_enable 0, UNSYNC_bus 0, gnt_a 0, gnt_b 0, busy 0, done 0, state IDLE, counter 0, last-grant pointer = B, so A wins the first tie.
- FSM states:
  - IDLE: no request → stay. Any request → arbitrate, load winner's data into UNSYNC_bus, pulse its gnt, go to SETUP.
  - SETUP: 1 cycle with data stable and bus_enable 0 → HIGH, load counter with HOLD_CYCLES-1.
  - HIGH: bus_enable 1, counter decrements. At 0 → LOW, load counter with GAP_CYCLES-1.
  - LOW: bus_enable 0, counter decrements. At 0 → IDLE, pulse done.
- UNSYNC_bus changes only at an IDLE acceptance edge. It holds its value through SETUP/HIGH/LOW and afterwards in IDLE.
- Requests are level-sensitive and sampled only in IDLE. Requests in other states are ignored, not queued. A requester keeps req and data stable until it sees gnt.
- A req still high in the cycle after gnt is a new word and is serviced in the next IDLE.
- Exactly one gnt per transfer. gnt_a and gnt_b are never high together.
- Arbitration is configured by the macro below. The pointer updates only on a grant.
- Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). No wrap: the counter is reloaded on every state entry.
- Reset mid-transfer: all state returns immediately to reset values. bus_enable drops asynchronously and the aborted word is lost with no done.

## Timing
- Request seen high at edge k in IDLE:
  - edge k: UNSYNC_bus updated, gnt high, busy high.
  - edge k+1: bus_enable rises.
  - edge k+1+HOLD_CYCLES: bus_enable falls.
  - edge k+1+HOLD_CYCLES+GAP_CYCLES: back in IDLE, done high for one cycle, busy low.
- Data set-up to bus_enable rise: exactly 1 CLK cycle.
- Back-to-back: if req is pending at the IDLE return edge, the next acceptance happens at the following edge. Transfer period = 2+HOLD_CYCLES+GAP_CYCLES cycles.
- done and the next-cycle acceptance never overlap with gnt in the same cycle.

## Configuration
- DSYNC_TX_RR_EN defined: round-robin. On a tie, grant the requester not granted last. A sole requester always wins.
- DSYNC_TX_RR_EN undefined: fixed priority, A over B. The pointer logic is removed, and B is served only when req_a is low in IDLE.

## Test plan
- Reset, then single A transfer with data_a=8'hF2 → gnt_a at edge 1, UNSYNC_bus=F2, bus_enable high for 6 cycles starting edge 2, low 6, done at edge 14, busy low after.
- req_a and req_b both held high with data_a=8'hAA and data_b=8'hBB, RR enabled → words sent A,B,A,B. Each gnt is one cycle, and consecutive gnts are 14 cycles apart.
- Same stimulus with DSYNC_TX_RR_EN undefined → only A granted while req_a high. Drop req_a → B granted at the next IDLE.
- req_b pulsed high during HIGH state and dropped before IDLE → no gnt_b, no extra transfer.
- RST_n asserted mid-HIGH → bus_enable, busy and UNSYNC_bus go 0 immediately with no done. After release, a new req_b of 8'hCC completes normally.
- Connect the destination synchronizer (4 stages, same clock) → one enable_pulse per transfer, and SYNC_bus equals the sent word each time.
